// File: rtl/renas_ahb2apb_bridge.sv
// AHB-lite responder driving one APB3 requester; each accepted AHB transfer becomes one SETUP/ACCESS pair.
// Optional ACCESS watchdog enabled by defining RENAS_APB_TIMEOUT_EN (TIMEOUT_CYCLES applies only then).
module renas_ahb2apb_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int APB_ADDR_WIDTH = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      hsel,
    input  logic [ADDR_WIDTH-1:0]     haddr,
    input  logic [1:0]                htrans,
    input  logic                      hwrite,
    input  logic [2:0]                hsize,
    input  logic [DATA_WIDTH-1:0]     hwdata,
    input  logic                      hready,
    output logic                      hreadyout,
    output logic                      hresp,
    output logic [DATA_WIDTH-1:0]     hrdata,
    output logic [APB_ADDR_WIDTH-1:0] paddr,
    output logic                      psel,
    output logic                      penable,
    output logic                      pwrite,
    output logic [DATA_WIDTH-1:0]     pwdata,
    output logic [DATA_WIDTH/8-1:0]   pstrb,
    input  logic [DATA_WIDTH-1:0]     prdata,
    input  logic                      pready,
    input  logic                      pslverr
);
    localparam int STRB_W = DATA_WIDTH / 8;

    // state_q is the FSM debug view; probe it hierarchically.
    typedef enum logic [2:0] {S_IDLE, S_WDATA, S_SETUP, S_ACCESS, S_ERR1, S_ERR2} state_e;
    state_e state_q, state_d;

    logic                      hreadyout_q, hreadyout_d;
    logic                      hresp_q, hresp_d;
    logic [DATA_WIDTH-1:0]     hrdata_q, hrdata_d;
    logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic                      psel_q, psel_d;
    logic                      penable_q, penable_d;
    logic                      pwrite_q, pwrite_d;
    logic [DATA_WIDTH-1:0]     pwdata_q, pwdata_d;
    logic [STRB_W-1:0]         pstrb_q, pstrb_d;

    logic              accept, size_err, timeout;
    logic [STRB_W-1:0] strb;
    logic              unused_bits;

`ifdef RENAS_APB_TIMEOUT_EN
    localparam int TO_W = ($clog2(TIMEOUT_CYCLES + 1) < 8) ? 8 : $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
`endif

    assign unused_bits = ^{haddr[ADDR_WIDTH-1:APB_ADDR_WIDTH], htrans[0]};

    // Handshakes: an AHB address phase is taken only in IDLE when hsel & hready & htrans[1];
    // an APB access completes on the first ACCESS cycle with pready=1, pslverr qualifying it.
    always_comb begin
        accept   = hsel && hready && htrans[1];
        size_err = (hsize > 3'd2) || ((hsize == 3'd1) && haddr[0]) ||
                   ((hsize == 3'd2) && (haddr[1:0] != 2'b00));
        case (hsize[1:0])
            2'd0:    strb = STRB_W'(1) << haddr[1:0];
            2'd1:    strb = STRB_W'(3) << haddr[1:0];
            default: strb = '1;
        endcase
    end

`ifdef RENAS_APB_TIMEOUT_EN
    always_comb begin
        to_cnt_d = to_cnt_q;
        timeout  = 1'b0;
        if (state_q == S_SETUP) begin
            to_cnt_d = '0;
        end else if (state_q == S_ACCESS && !pready) begin
            to_cnt_d = to_cnt_q + 1'b1;
            timeout  = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        hreadyout_d = hreadyout_q;
        hresp_d     = hresp_q;
        hrdata_d    = hrdata_q;
        paddr_d     = paddr_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;
        pstrb_d     = pstrb_q;
        case (state_q)
            S_IDLE: begin
                hreadyout_d = 1'b1;
                hresp_d     = 1'b0;
                psel_d      = 1'b0;
                penable_d   = 1'b0;
                if (accept) begin
                    hreadyout_d = 1'b0;
                    if (size_err) begin
                        state_d = S_ERR1;
                        hresp_d = 1'b1;
                    end else begin
                        paddr_d  = haddr[APB_ADDR_WIDTH-1:0];
                        pwrite_d = hwrite;
                        pstrb_d  = hwrite ? strb : '0;
                        if (hwrite) begin
                            state_d = S_WDATA;
                        end else begin
                            state_d = S_SETUP;
                            psel_d  = 1'b1;
                        end
                    end
                end
            end
            S_WDATA: begin
                pwdata_d = hwdata;
                psel_d   = 1'b1;
                state_d  = S_SETUP;
            end
            S_SETUP: begin
                penable_d = 1'b1;
                state_d   = S_ACCESS;
            end
            S_ACCESS: begin
                if (pready) begin
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    if (pslverr) begin
                        state_d = S_ERR1;
                        hresp_d = 1'b1;
                    end else begin
                        state_d     = S_IDLE;
                        hreadyout_d = 1'b1;
                        if (!pwrite_q) hrdata_d = prdata;
                    end
                end else if (timeout) begin
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    state_d   = S_ERR1;
                    hresp_d   = 1'b1;
                end
            end
            S_ERR1: begin
                hreadyout_d = 1'b1;
                state_d     = S_ERR2;
            end
            // Any address phase seen here is dropped; the master cancels it after ERROR.
            S_ERR2: begin
                hresp_d = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
            hrdata_q    <= '0;
            paddr_q     <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
`ifdef RENAS_APB_TIMEOUT_EN
            to_cnt_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
            hrdata_q    <= hrdata_d;
            paddr_q     <= paddr_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            pstrb_q     <= pstrb_d;
`ifdef RENAS_APB_TIMEOUT_EN
            to_cnt_q    <= to_cnt_d;
`endif
        end
    end

    assign hreadyout = hreadyout_q;
    assign hresp     = hresp_q;
    assign hrdata    = hrdata_q;
    assign paddr     = paddr_q;
    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign pwdata    = pwdata_q;
    assign pstrb     = pstrb_q;

endmodule

// File: tb/tb_renas_ahb2apb_bridge.sv
// Directed bench for renas_ahb2apb_bridge: reset, read, write, errors, back-to-back, reset mid-access.
module tb_renas_ahb2apb_bridge;
    logic        clk = 1'b0;
    logic        rst;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        hready;
    logic        hreadyout;
    logic        hresp;
    logic [31:0] hrdata;
    logic [15:0] paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int total = 0;
    int bad   = 0;

    renas_ahb2apb_bridge #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .APB_ADDR_WIDTH(16), .TIMEOUT_CYCLES(4)
    ) dut (
        .clk(clk), .rst(rst), .hsel(hsel), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
        .hsize(hsize), .hwdata(hwdata), .hready(hready), .hreadyout(hreadyout), .hresp(hresp),
        .hrdata(hrdata), .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
        .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_addr(input logic [31:0] a, input logic w, input logic [2:0] sz);
        hsel = 1'b1; haddr = a; htrans = 2'b10; hwrite = w; hsize = sz;
    endtask

    task automatic bus_idle();
        hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick(); tick();
        total++; if (hreadyout !== 1'b1) begin bad++; $display("FAIL rst_hreadyout got=%h exp=1", hreadyout); end
        total++; if (hresp !== 1'b0) begin bad++; $display("FAIL rst_hresp got=%h exp=0", hresp); end
        total++; if (hrdata !== 32'h0) begin bad++; $display("FAIL rst_hrdata got=%h exp=0", hrdata); end
        total++; if ({psel, penable, pwrite} !== 3'b000) begin bad++; $display("FAIL rst_apb_ctl got=%b exp=000", {psel, penable, pwrite}); end
        total++; if (paddr !== 16'h0) begin bad++; $display("FAIL rst_paddr got=%h exp=0", paddr); end
        total++; if (pwdata !== 32'h0) begin bad++; $display("FAIL rst_pwdata got=%h exp=0", pwdata); end
        total++; if (pstrb !== 4'h0) begin bad++; $display("FAIL rst_pstrb got=%h exp=0", pstrb); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_word_read();
        drive_addr(32'h4000_0010, 1'b0, 3'd2);
        tick();  // N+1 SETUP
        bus_idle();
        total++; if ({psel, penable, hreadyout} !== 3'b100) begin bad++; $display("FAIL rd_setup psel/pen/hrdy got=%b exp=100", {psel, penable, hreadyout}); end
        total++; if (paddr !== 16'h0010) begin bad++; $display("FAIL rd_paddr got=%h exp=0010", paddr); end
        total++; if ({pwrite, pstrb} !== 5'b0_0000) begin bad++; $display("FAIL rd_pwrite_pstrb got=%b exp=00000", {pwrite, pstrb}); end
        tick();  // N+2 ACCESS
        pready = 1'b1; prdata = 32'hDEAD_BEEF;
        total++; if ({psel, penable, hreadyout} !== 3'b110) begin bad++; $display("FAIL rd_access psel/pen/hrdy got=%b exp=110", {psel, penable, hreadyout}); end
        tick();  // N+3 done
        pready = 1'b0; prdata = 32'h0;
        total++; if ({hreadyout, hresp} !== 2'b10) begin bad++; $display("FAIL rd_done hrdy/hresp got=%b exp=10", {hreadyout, hresp}); end
        total++; if (hrdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rd_hrdata got=%h exp=deadbeef", hrdata); end
        total++; if ({psel, penable} !== 2'b00) begin bad++; $display("FAIL rd_done_apb got=%b exp=00", {psel, penable}); end
    endtask

    task automatic test_byte_write();
        int low = 0;
        drive_addr(32'h4000_0006, 1'b1, 3'd0);
        tick();  // N+1 WDATA
        bus_idle();
        hwdata = 32'h00AB_0000;
        if (hreadyout === 1'b0) low++;
        total++; if (psel !== 1'b0) begin bad++; $display("FAIL wr_wdata psel got=%h exp=0", psel); end
        tick();  // N+2 SETUP
        hwdata = 32'hFFFF_FFFF;
        if (hreadyout === 1'b0) low++;
        total++; if ({psel, penable, pwrite} !== 3'b101) begin bad++; $display("FAIL wr_setup psel/pen/pwr got=%b exp=101", {psel, penable, pwrite}); end
        total++; if (paddr !== 16'h0006) begin bad++; $display("FAIL wr_paddr got=%h exp=0006", paddr); end
        for (int k = 0; k < 4; k++) begin
            tick();  // ACCESS cycles N+3..N+6
            pready = (k == 3);
            if (hreadyout === 1'b0) low++;
            total++; if ({psel, penable} !== 2'b11) begin bad++; $display("FAIL wr_access%0d psel/pen got=%b exp=11", k, {psel, penable}); end
            total++; if (pstrb !== 4'b0100) begin bad++; $display("FAIL wr_pstrb%0d got=%b exp=0100", k, pstrb); end
            total++; if (pwdata !== 32'h00AB_0000) begin bad++; $display("FAIL wr_pwdata%0d got=%h exp=00ab0000", k, pwdata); end
        end
        tick();  // N+7 done
        pready = 1'b0;
        total++; if (low !== 6) begin bad++; $display("FAIL wr_wait_states got=%0d exp=6", low); end
        total++; if ({hreadyout, hresp, psel, penable} !== 4'b1000) begin bad++; $display("FAIL wr_done got=%b exp=1000", {hreadyout, hresp, psel, penable}); end
        total++; if (hrdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL wr_hrdata_hold got=%h exp=deadbeef", hrdata); end
    endtask

    task automatic test_slverr();
        drive_addr(32'h4000_0020, 1'b0, 3'd2);
        tick();  // SETUP
        bus_idle();
        tick();  // ACCESS
        pready = 1'b1; pslverr = 1'b1; prdata = 32'h1234_5678;
        tick();  // ERR1
        pready = 1'b0; pslverr = 1'b0; prdata = 32'h0;
        total++; if ({hresp, hreadyout, psel, penable} !== 4'b1000) begin bad++; $display("FAIL slv_err1 got=%b exp=1000", {hresp, hreadyout, psel, penable}); end
        tick();  // ERR2
        total++; if ({hresp, hreadyout} !== 2'b11) begin bad++; $display("FAIL slv_err2 got=%b exp=11", {hresp, hreadyout}); end
        tick();  // IDLE
        total++; if ({hresp, hreadyout} !== 2'b01) begin bad++; $display("FAIL slv_idle got=%b exp=01", {hresp, hreadyout}); end
        total++; if (hrdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL slv_hrdata got=%h exp=deadbeef", hrdata); end
    endtask

    task automatic test_size_err();
        drive_addr(32'h4000_0012, 1'b0, 3'd2);
        tick();  // ERR1
        bus_idle();
        total++; if ({hresp, hreadyout, psel} !== 3'b100) begin bad++; $display("FAIL sz_word_err1 got=%b exp=100", {hresp, hreadyout, psel}); end
        tick();  // ERR2, present a read that must be ignored
        drive_addr(32'h4000_0030, 1'b0, 3'd2);
        total++; if ({hresp, hreadyout, psel} !== 3'b110) begin bad++; $display("FAIL sz_word_err2 got=%b exp=110", {hresp, hreadyout, psel}); end
        tick();
        bus_idle();
        total++; if ({hresp, hreadyout, psel} !== 3'b010) begin bad++; $display("FAIL sz_ignored got=%b exp=010", {hresp, hreadyout, psel}); end
        drive_addr(32'h4000_0031, 1'b1, 3'd1);  // misaligned halfword
        tick();
        bus_idle();
        total++; if ({hresp, hreadyout, psel} !== 3'b100) begin bad++; $display("FAIL sz_half_err1 got=%b exp=100", {hresp, hreadyout, psel}); end
        tick(); tick();
        drive_addr(32'h4000_0030, 1'b0, 3'd3);  // oversize
        tick();
        bus_idle();
        total++; if ({hresp, hreadyout, psel} !== 3'b100) begin bad++; $display("FAIL sz_big_err1 got=%b exp=100", {hresp, hreadyout, psel}); end
        tick(); tick();
        hsel = 1'b1; htrans = 2'b01; haddr = 32'h4000_0040; hsize = 3'd2;  // BUSY
        for (int k = 0; k < 2; k++) begin
            tick();
            total++; if ({hreadyout, hresp, psel} !== 3'b100) begin bad++; $display("FAIL busy%0d got=%b exp=100", k, {hreadyout, hresp, psel}); end
        end
        bus_idle();
    endtask

    task automatic test_back_to_back();
        drive_addr(32'h4000_000A, 1'b1, 3'd1);
        tick();  // WDATA
        bus_idle();
        hwdata = 32'h1234_0000;
        tick();  // SETUP
        total++; if (pstrb !== 4'b1100) begin bad++; $display("FAIL b2b_pstrb got=%b exp=1100", pstrb); end
        total++; if (paddr !== 16'h000A) begin bad++; $display("FAIL b2b_paddr got=%h exp=000a", paddr); end
        tick();  // ACCESS
        pready = 1'b1;
        tick();  // completion cycle: present next read
        pready = 1'b0;
        total++; if (hreadyout !== 1'b1) begin bad++; $display("FAIL b2b_wr_done got=%h exp=1", hreadyout); end
        drive_addr(32'h4000_0040, 1'b0, 3'd2);
        tick();  // SETUP of read
        bus_idle();
        total++; if ({psel, penable, pwrite, pstrb} !== 7'b100_0000) begin bad++; $display("FAIL b2b_rd_setup got=%b exp=1000000", {psel, penable, pwrite, pstrb}); end
        total++; if (paddr !== 16'h0040) begin bad++; $display("FAIL b2b_rd_paddr got=%h exp=0040", paddr); end
        tick();  // ACCESS
        pready = 1'b1; prdata = 32'h55AA_33CC;
        tick();
        pready = 1'b0; prdata = 32'h0;
        total++; if ({hreadyout, hresp} !== 2'b10 || hrdata !== 32'h55AA_33CC) begin bad++; $display("FAIL b2b_rd_done hrdy/hresp=%b hrdata=%h exp 10/55aa33cc", {hreadyout, hresp}, hrdata); end
    endtask

    task automatic test_reset_mid();
        drive_addr(32'h4000_0050, 1'b0, 3'd2);
        tick();  // SETUP
        bus_idle();
        tick();  // ACCESS, peripheral stalls
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if ({psel, penable, hreadyout, hresp} !== 4'b0010) begin bad++; $display("FAIL rstmid_ctl got=%b exp=0010", {psel, penable, hreadyout, hresp}); end
        total++; if (hrdata !== 32'h0) begin bad++; $display("FAIL rstmid_hrdata got=%h exp=0", hrdata); end
        tick();
        drive_addr(32'h4000_0010, 1'b0, 3'd2);
        tick();
        bus_idle();
        tick();
        pready = 1'b1; prdata = 32'h0BAD_F00D;
        tick();
        pready = 1'b0; prdata = 32'h0;
        total++; if ({hreadyout, hresp} !== 2'b10 || hrdata !== 32'h0BAD_F00D) begin bad++; $display("FAIL rstmid_fresh hrdy/hresp=%b hrdata=%h exp 10/0badf00d", {hreadyout, hresp}, hrdata); end
    endtask

`ifdef RENAS_APB_TIMEOUT_EN
    task automatic test_timeout();
        drive_addr(32'h4000_0060, 1'b0, 3'd2);
        tick();
        bus_idle();
        for (int k = 0; k < 4; k++) begin
            tick();
            total++; if ({psel, penable} !== 2'b11) begin bad++; $display("FAIL to_access%0d got=%b exp=11", k, {psel, penable}); end
        end
        tick();
        total++; if ({psel, penable, hresp, hreadyout} !== 4'b0010) begin bad++; $display("FAIL to_err1 got=%b exp=0010", {psel, penable, hresp, hreadyout}); end
        tick();
        total++; if ({hresp, hreadyout} !== 2'b11) begin bad++; $display("FAIL to_err2 got=%b exp=11", {hresp, hreadyout}); end
        tick();
        drive_addr(32'h4000_0064, 1'b0, 3'd2);
        tick();
        bus_idle();
        for (int k = 0; k < 4; k++) begin
            tick();
            pready = (k == 3); prdata = 32'h7777_1111;
        end
        tick();
        pready = 1'b0;
        total++; if ({hreadyout, hresp} !== 2'b10 || hrdata !== 32'h7777_1111) begin bad++; $display("FAIL to_late_ready hrdy/hresp=%b hrdata=%h exp 10/77771111", {hreadyout, hresp}, hrdata); end
    endtask
`endif

    initial begin
        rst = 1'b1; hready = 1'b1; hwdata = 32'h0;
        haddr = 32'h0; prdata = 32'h0; pready = 1'b0; pslverr = 1'b0;
        bus_idle();
        #1;
        test_reset();
        test_word_read();
        test_byte_write();
        test_slverr();
        test_size_err();
        test_back_to_back();
        test_reset_mid();
`ifdef RENAS_APB_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
